exe_stage_ctrl: RTL and testbench

Execute-stage pipeline register and handshake controller for the five-stage in-order core. It accepts instructions from decode, honours the load-use stall request from the hazard detector, and holds multi-cycle operations for a fixed latency. It then hands results to memory through the valid/allowin handshake. It also drives the execute-stage destination and load-op fields that the load-use detector compares against decode source registers.

---
 rtl/exe_stage_ctrl_if.sv | 33 +++
 rtl/exe_stage_ctrl.sv | 133 +++++++++++++
 tb/tb_exe_stage_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_ctrl_if.sv
// Decode/memory-facing handshake and payload bundle for the execute stage.
// The slave modport is the execute stage; the master modport is whatever
// drives it (the decode, hazard and memory sides, or a testbench).
interface exe_stage_ctrl_if #(
  parameter int BUS_WD = 150
);
  logic              ds_to_es_valid;
  logic [BUS_WD-1:0] ds_to_es_bus;
  logic [4:0]        ds_dest;
  logic [4:0]        ds_load_op;
  logic              ds_mc_op;
  logic              lu_stall;
  logic              es_flush;
  logic              ms_allowin;
  logic              es_allowin;
  logic              ds_go;
  logic              es_to_ms_valid;
  logic [BUS_WD-1:0] es_to_ms_bus;
  logic [9:0]        es_to_lu_bus;
  logic              es_busy;

  modport slave (
    input  ds_to_es_valid, ds_to_es_bus, ds_dest, ds_load_op, ds_mc_op,
    input  lu_stall, es_flush, ms_allowin,
    output es_allowin, ds_go, es_to_ms_valid, es_to_ms_bus, es_to_lu_bus, es_busy
  );

  modport master (
    output ds_to_es_valid, ds_to_es_bus, ds_dest, ds_load_op, ds_mc_op,
    output lu_stall, es_flush, ms_allowin,
    input  es_allowin, ds_go, es_to_ms_valid, es_to_ms_bus, es_to_lu_bus, es_busy
  );
endinterface

// File: rtl/exe_stage_ctrl.sv
// Execute-stage pipeline register and valid/allowin controller.
// Single-cycle ops pass through in one cycle; multi-cycle ops sit in ES for
// MC_LAT cycles (legal 2..16), counted by a small IDLE/RUN/DONE machine.
// es_to_lu_bus is built only from registers so the load-use detector never
// sees a combinational path back from the decode inputs.
module exe_stage_ctrl #(
  parameter int BUS_WD = 150,
  parameter int MC_LAT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  exe_stage_ctrl_if.slave bus_if
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  // RUN lasts MC_LAT-1 cycles: cnt counts down to zero, then one more edge to DONE.
  localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 2);

  logic              r_valid;
  logic [BUS_WD-1:0] r_payload;
  logic [4:0]        r_dest;
  logic [4:0]        r_load_op;
  logic              r_mc;
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;

  logic [1:0]        w_state_nxt;
  logic [3:0]        w_cnt_nxt;
  logic              w_ready_go;
  logic              w_allowin;
  logic              w_ds_go;

  assign w_ready_go = !r_mc || (r_state == S_DONE);
  assign w_allowin  = !r_valid || (w_ready_go && bus_if.ms_allowin);
  assign w_ds_go    = bus_if.ds_to_es_valid && w_allowin && !bus_if.lu_stall && !bus_if.es_flush;

  assign bus_if.es_allowin     = w_allowin;
  assign bus_if.ds_go          = w_ds_go;
  assign bus_if.es_to_ms_valid = r_valid && w_ready_go;
  assign bus_if.es_to_ms_bus   = r_payload;
  assign bus_if.es_to_lu_bus   = r_valid ? {r_dest, r_load_op} : 10'd0;
  assign bus_if.es_busy        = (r_state == S_RUN);

  // Next-state/counter logic; flush wins, then a fresh accept, then normal counting.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus_if.es_flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
    end else if (w_ds_go) begin
      // An accept in DONE implies the old op is leaving, so RUN reloads without an IDLE gap.
      if (bus_if.ds_mc_op) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = CNT_INIT;
      end else begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_RUN: begin
          if (r_cnt == 4'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (w_allowin) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // State machine and latency counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ES valid bit: cleared by flush, refilled or bubbled whenever ES can accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else if (bus_if.es_flush) begin
      r_valid <= 1'b0;
    end else if (w_allowin) begin
      r_valid <= w_ds_go;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Payload and hazard fields; only a transfer from decode changes them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_payload <= '0;
      r_dest    <= 5'd0;
      r_load_op <= 5'd0;
      r_mc      <= 1'b0;
    end else if (w_ds_go) begin
      r_payload <= bus_if.ds_to_es_bus;
      r_dest    <= bus_if.ds_dest;
      r_load_op <= bus_if.ds_load_op;
      r_mc      <= bus_if.ds_mc_op;
    end else begin
      r_payload <= r_payload;
      r_dest    <= r_dest;
      r_load_op <= r_load_op;
      r_mc      <= r_mc;
    end
  end

endmodule

// File: tb/tb_exe_stage_ctrl.sv
// Bench for exe_stage_ctrl: directed scenarios followed by random traffic,
// every output compared against a slot-occupancy model of the execute stage.
module tb_exe_stage_ctrl;
  localparam int BUS_WD = 150;
  localparam int MC_LAT = 4;

  logic clk;
  logic resetn;
  int   n_total;
  int   n_pass;

  // Reference model: one ES slot plus "cycles remaining before ready".
  logic              m_valid;
  int                m_wait;
  logic [BUS_WD-1:0] m_payload;
  logic [4:0]        m_dest;
  logic [4:0]        m_lo;
  logic              p_allowin;
  logic              p_go;

  exe_stage_ctrl_if #(.BUS_WD(BUS_WD)) bif ();

  exe_stage_ctrl #(.BUS_WD(BUS_WD), .MC_LAT(MC_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus_if (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BUS_WD-1:0] rnd_bus();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[BUS_WD-1:0];
  endfunction

  task automatic chk(input string step, input string field,
                     input logic [BUS_WD-1:0] obs, input logic [BUS_WD-1:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s %s observed=%0h expected=%0h", step, field, obs, exp);
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_wait    = 0;
    m_payload = '0;
    m_dest    = 5'd0;
    m_lo      = 5'd0;
  endtask

  // Compare all outputs against the model under the currently driven inputs.
  task automatic check_now(input string step);
    logic       e_ready;
    logic [9:0] e_lu;
    e_ready   = (m_wait == 0);
    p_allowin = !m_valid || (e_ready && bif.ms_allowin);
    p_go      = bif.ds_to_es_valid && p_allowin && !bif.lu_stall && !bif.es_flush;
    e_lu      = m_valid ? {m_dest, m_lo} : 10'd0;
    chk(step, "es_allowin", {149'd0, bif.es_allowin}, {149'd0, p_allowin});
    chk(step, "ds_go", {149'd0, bif.ds_go}, {149'd0, p_go});
    chk(step, "es_to_ms_valid", {149'd0, bif.es_to_ms_valid}, {149'd0, m_valid && e_ready});
    chk(step, "es_to_ms_bus", bif.es_to_ms_bus, m_payload);
    chk(step, "es_to_lu_bus", {140'd0, bif.es_to_lu_bus}, {140'd0, e_lu});
    chk(step, "es_busy", {149'd0, bif.es_busy}, {149'd0, m_valid && (m_wait > 0)});
  endtask

  // Advance the model across one clock edge using the inputs seen at that edge.
  task automatic model_step();
    if (bif.es_flush) begin
      m_valid = 1'b0;
      m_wait  = 0;
    end else if (p_allowin) begin
      if (p_go) begin
        m_valid   = 1'b1;
        m_payload = bif.ds_to_es_bus;
        m_dest    = bif.ds_dest;
        m_lo      = bif.ds_load_op;
        m_wait    = bif.ds_mc_op ? MC_LAT - 1 : 0;
      end else begin
        m_valid = 1'b0;
      end
    end else if (m_wait > 0) begin
      m_wait = m_wait - 1;
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] dest, input logic [4:0] lo,
                       input logic mc, input logic stall, input logic flush, input logic msa);
    bif.ds_to_es_valid = v;
    bif.ds_to_es_bus   = rnd_bus();
    bif.ds_dest        = dest;
    bif.ds_load_op     = lo;
    bif.ds_mc_op       = mc;
    bif.lu_stall       = stall;
    bif.es_flush       = flush;
    bif.ms_allowin     = msa;
  endtask

  task automatic cycle(input string step, input logic v, input logic [4:0] dest,
                       input logic [4:0] lo, input logic mc, input logic stall,
                       input logic flush, input logic msa);
    drive(v, dest, lo, mc, stall, flush, msa);
    @(negedge clk);
    check_now(step);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    model_reset();
    resetn = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    check_now("reset_init");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check_now("reset_release");
    @(posedge clk);
    model_step();
    #1;

    // Single-cycle stream, dest 5/6/7.
    cycle("stream0", 1'b1, 5'd5, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("stream1", 1'b1, 5'd6, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("stream2", 1'b1, 5'd7, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("stream3", 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("stream4", 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Load-use: load in ES, dependent op stalled one cycle, then enters.
    cycle("lu_load", 1'b1, 5'd4, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("lu_stall", 1'b1, 5'd9, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle("lu_bubble", 1'b1, 5'd9, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("lu_dep", 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Multi-cycle op with memory always ready.
    cycle("mc_acc", 1'b1, 5'd10, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < MC_LAT + 1; i++) begin
      cycle("mc_run", 1'b1, 5'd11, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    cycle("mc_tail", 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure in DONE with a queued multi-cycle op.
    cycle("bp_acc", 1'b1, 5'd12, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < MC_LAT - 1; i++) begin
      cycle("bp_run", 1'b1, 5'd13, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    cycle("bp_hold0", 1'b1, 5'd13, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("bp_hold1", 1'b1, 5'd13, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("bp_leave", 1'b1, 5'd13, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < MC_LAT + 1; i++) begin
      cycle("bp_next", 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Flush during RUN with decode offering an op.
    cycle("fl_acc", 1'b1, 5'd14, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle("fl_run", 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("fl_flush", 1'b1, 5'd15, 5'b00100, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("fl_after", 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-RUN, then a normal first load.
    cycle("rst_acc", 1'b1, 5'd3, 5'b01000, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle("rst_run", 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'd17, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_now("rst_mid_run");
    @(posedge clk);
    #2;
    check_now("rst_held");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check_now("rst_first_go");
    @(posedge clk);
    model_step();
    #1;
    cycle("rst_after", 1'b0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)),
            ($urandom_range(0, 1) != 0) ? (5'd1 << $urandom_range(0, 4)) : 5'd0,
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
